// File: rtl/channel_pulse_voice_pkg.sv
// ---------------------------------------------------------------------------
// channel_pulse_voice_pkg
// Shared definitions for the per-channel pulse voice and its neighbours.
//   voice_state_e     : voice run state (SILENT=0, RUN=1)
//   DEFAULT_TOP       : reset duty threshold, 50% duty for an 8-bit top
//   *_DEFAULT         : default widths, shared with the channel mixer
// ---------------------------------------------------------------------------
package channel_pulse_voice_pkg;

  typedef enum logic {
    VOICE_SILENT = 1'b0,
    VOICE_RUN    = 1'b1
  } voice_state_e;

  localparam logic [7:0] DEFAULT_TOP = 8'h80;

  localparam int PHASE_W_DEFAULT   = 32;
  localparam int TOP_W_DEFAULT     = 8;
  localparam int ENV_W_DEFAULT     = 9;
  localparam int SAMPLE_W_DEFAULT  = 16;
  localparam int ENV_SHIFT_DEFAULT = 6;

endpackage

// File: rtl/channel_pulse_voice_phase_accumulator.sv
// ---------------------------------------------------------------------------
// channel_pulse_voice_phase_accumulator
// Wrapping phase accumulator, reusable by any channel voice.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : add i_delta to the phase this cycle
//   i_clr          : synchronously clear the phase (wins over i_en)
//   i_delta        : phase increment
//   o_phase        : registered phase
//   o_wrap         : registered one-cycle pulse, carry out of the last add
//   o_phase_next   : phase value that will be loaded at the next edge
//   o_wrap_next    : carry that will be registered at the next edge
// ---------------------------------------------------------------------------
module channel_pulse_voice_phase_accumulator
  import channel_pulse_voice_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_clr,
  input  logic [PHASE_W-1:0] i_delta,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_wrap,
  output logic [PHASE_W-1:0] o_phase_next,
  output logic               o_wrap_next
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               wrap_q, wrap_d;
  logic [PHASE_W-1:0] sum;
  logic               carry;

  // Next phase: clear forces zero with no wrap, otherwise add when enabled
  // and report the carry out of the top bit as the wrap event.
  always_comb begin
    {carry, sum} = {1'b0, phase_q} + {1'b0, i_delta};
    phase_d      = phase_q;
    wrap_d       = 1'b0;
    if (i_clr) begin
      phase_d = '0;
    end else if (i_en) begin
      phase_d = sum;
      wrap_d  = carry;
    end
  end

  // Phase and wrap-pulse registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_phase      = phase_q;
  assign o_wrap       = wrap_q;
  assign o_phase_next = phase_d;
  assign o_wrap_next  = wrap_d;

endmodule

// File: rtl/channel_pulse_voice.sv
// ---------------------------------------------------------------------------
// channel_pulse_voice
// Pulse-wave voice for one channel: accumulates phase on each sample strobe,
// compares the phase MSBs with a duty threshold and emits +/- envelope
// scaled signed PCM, two cycles after the strobe.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_sample_stb     : sample-rate strobe (may be high every cycle)
//   i_phase_delta    : per-sample phase increment, 0 = rest
//   i_top/_valid     : duty threshold and its qualifier
//   i_envelope       : unsigned amplitude
//   o_sample/_valid  : signed sample and its one-cycle valid
//   o_period_stb     : one-cycle pulse when the phase wraps
//   o_phase          : current accumulator value
// ENV_W + ENV_SHIFT must stay below SAMPLE_W so +/-mag never overflows.
// ---------------------------------------------------------------------------
module channel_pulse_voice
  import channel_pulse_voice_pkg::*;
#(
  parameter int PHASE_W   = PHASE_W_DEFAULT,
  parameter int TOP_W     = TOP_W_DEFAULT,
  parameter int ENV_W     = ENV_W_DEFAULT,
  parameter int SAMPLE_W  = SAMPLE_W_DEFAULT,
  parameter int ENV_SHIFT = ENV_SHIFT_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sample_stb,
  input  logic [PHASE_W-1:0]  i_phase_delta,
  input  logic [TOP_W-1:0]    i_top,
  input  logic                i_top_valid,
  input  logic [ENV_W-1:0]    i_envelope,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic                o_sample_valid,
  output logic                o_period_stb,
  output logic [PHASE_W-1:0]  o_phase
);

  localparam logic [TOP_W-1:0] TOP_RESET = TOP_W'(DEFAULT_TOP);

  voice_state_e        state_q, state_d;
  logic [TOP_W-1:0]    top_active_q, top_active_d;
  logic [TOP_W-1:0]    top_pending_q, top_pending_d;
  logic                s1_valid_q, s1_valid_d;
  logic                pulse_hi_q, pulse_hi_d;
  logic [ENV_W-1:0]    env_q, env_d;
  logic                silent_q, silent_d;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic                sample_valid_q, sample_valid_d;

  logic                delta_zero;
  logic                acc_en, acc_clr;
  logic [PHASE_W-1:0]  phase_next;
  logic                wrap_next;
  logic [SAMPLE_W-1:0] mag;

  // A zero delta on a strobe rests the voice and clears the phase; any other
  // delta accumulates, including on the strobe that leaves SILENT.
  assign delta_zero = (i_phase_delta == '0);
  assign acc_en     = i_sample_stb && !delta_zero;
  assign acc_clr    = i_sample_stb && delta_zero;

  channel_pulse_voice_phase_accumulator #(
    .PHASE_W(PHASE_W)
  ) u_phase_acc (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_en         (acc_en),
    .i_clr        (acc_clr),
    .i_delta      (i_phase_delta),
    .o_phase      (o_phase),
    .o_wrap       (o_period_stb),
    .o_phase_next (phase_next),
    .o_wrap_next  (wrap_next)
  );

  // Next-state logic for the run state, the duty registers and both
  // pipeline stages. The active top only moves on a wrap so a period never
  // changes duty halfway; a top presented on the wrap cycle itself wins.
  always_comb begin
    state_d = state_q;
    if (i_sample_stb) begin
      case (state_q)
        VOICE_SILENT: if (!delta_zero) state_d = VOICE_RUN;
        VOICE_RUN:    if (delta_zero)  state_d = VOICE_SILENT;
        default:      state_d = VOICE_SILENT;
      endcase
    end

    top_pending_d = i_top_valid ? i_top : top_pending_q;
    top_active_d  = top_active_q;
    if (wrap_next) begin
      top_active_d = i_top_valid ? i_top : top_pending_q;
    end

    s1_valid_d = i_sample_stb;
    pulse_hi_d = pulse_hi_q;
    env_d      = env_q;
    silent_d   = silent_q;
    if (i_sample_stb) begin
      pulse_hi_d = (phase_next[PHASE_W-1 -: TOP_W] < top_active_d);
      env_d      = i_envelope;
      silent_d   = (state_d == VOICE_SILENT);
    end

    mag            = SAMPLE_W'(env_q) << ENV_SHIFT;
    sample_valid_d = s1_valid_q;
    sample_d       = sample_q;
    if (s1_valid_q) begin
      if (silent_q) begin
        sample_d = '0;
      end else if (pulse_hi_q) begin
        sample_d = mag;
      end else begin
        sample_d = -mag;
      end
    end
  end

  // All voice state and output registers; reset discards anything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= VOICE_SILENT;
      top_active_q   <= TOP_RESET;
      top_pending_q  <= TOP_RESET;
      s1_valid_q     <= 1'b0;
      pulse_hi_q     <= 1'b0;
      env_q          <= '0;
      silent_q       <= 1'b1;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      top_active_q   <= top_active_d;
      top_pending_q  <= top_pending_d;
      s1_valid_q     <= s1_valid_d;
      pulse_hi_q     <= pulse_hi_d;
      env_q          <= env_d;
      silent_q       <= silent_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign o_sample       = sample_q;
  assign o_sample_valid = sample_valid_q;

endmodule

// File: tb/tb_channel_pulse_voice.sv
// ---------------------------------------------------------------------------
// tb_channel_pulse_voice
// Scoreboard bench for channel_pulse_voice: the driver computes expected
// phase/wrap/sample values from plain arithmetic and queues them; a monitor
// pops and compares whenever the DUT presents the corresponding output.
// ---------------------------------------------------------------------------
module tb_channel_pulse_voice;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb;
  logic [31:0] delta;
  logic [7:0]  top;
  logic        topValid;
  logic [8:0]  env;
  logic [15:0] sample;
  logic        sampleValid;
  logic        periodStb;
  logic [31:0] phase;

  typedef struct {
    logic [31:0] phase;
    bit          wrap;
  } stage1Exp_t;

  stage1Exp_t stage1Q[$];
  int         sampleQ[$];
  stage1Exp_t e1;
  int         es;

  int checksTotal  = 0;
  int checksPassed = 0;

  // Reference model state: phase as a wide integer plus the two duty values.
  longint unsigned mPhase      = 0;
  int              mTopActive  = 8'h80;
  int              mTopPending = 8'h80;
  int              wrapsSeen;

  bit stb1, stb2;

  always #5 clk = ~clk;

  channel_pulse_voice dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sample_stb   (stb),
    .i_phase_delta  (delta),
    .i_top          (top),
    .i_top_valid    (topValid),
    .i_envelope     (env),
    .o_sample       (sample),
    .o_sample_valid (sampleValid),
    .o_period_stb   (periodStb),
    .o_phase        (phase)
  );

  task automatic checkOutput(input string name, input longint got, input longint exp);
    checksTotal++;
    if (got == exp) checksPassed++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Expected response of one strobe, derived from the behavioural rules.
  task automatic modelStrobe(input logic [31:0] d, input logic [7:0] t,
                             input bit tv, input logic [8:0] e);
    longint unsigned sum;
    bit wrap;
    int s;
    stage1Exp_t x;
    if (d == 0) begin
      mPhase = 0;
      wrap   = 0;
      s      = 0;
    end else begin
      sum    = mPhase + longint'(d);
      wrap   = (sum >= 64'h1_0000_0000);
      mPhase = sum % 64'h1_0000_0000;
      if (wrap) mTopActive = tv ? int'(t) : mTopPending;
      if ((mPhase >> 24) < longint'(mTopActive)) s = int'(e) * 64;
      else s = -(int'(e) * 64);
    end
    x.phase = mPhase[31:0];
    x.wrap  = wrap;
    stage1Q.push_back(x);
    sampleQ.push_back(s);
  endtask

  // Drive one clock cycle of inputs; delta/envelope are junk off-strobe.
  task automatic applyStimulus(input bit s, input logic [31:0] d, input logic [7:0] t,
                               input bit tv, input logic [8:0] e);
    @(posedge clk);
    #1;
    stb      = s;
    top      = t;
    topValid = tv;
    if (s) begin
      delta = d;
      env   = e;
      modelStrobe(d, t, tv, e);
    end else begin
      delta = $urandom;
      env   = 9'($urandom);
    end
    if (tv) mTopPending = int'(t);
  endtask

  // Strobe history as seen by the DUT, used to know when outputs are due.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb1 <= 1'b0;
      stb2 <= 1'b0;
    end else begin
      stb2 <= stb1;
      stb1 <= stb;
    end
  end

  // Monitor: compare stage-1 outputs and samples against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stb1) begin
        if (stage1Q.size() == 0) begin
          checkOutput("stage1_queue_nonempty", stage1Q.size(), 1);
        end else begin
          e1 = stage1Q.pop_front();
          checkOutput("phase", phase, e1.phase);
          checkOutput("period_stb", periodStb, e1.wrap);
        end
      end else begin
        checkOutput("period_stb_idle", periodStb, 0);
      end
      checkOutput("sample_valid_latency", sampleValid, stb2);
      if (sampleValid) begin
        if (sampleQ.size() == 0) begin
          checkOutput("unexpected_valid", sampleQ.size(), 1);
        end else begin
          es = sampleQ.pop_front();
          checkOutput("sample", longint'($signed(sample)), es);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    rst_n = 1'b0; stb = 0; delta = 0; top = 0; topValid = 0; env = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_sample", sample, 0);
    checkOutput("reset_valid", sampleValid, 0);
    checkOutput("reset_period", periodStb, 0);
    checkOutput("reset_phase", phase, 0);
    rst_n = 1'b1;

    // Basic square wave, strobe every 4 cycles, top held valid.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 32'h0100_0000, 8'h80, 1, 9'd30);
      repeat (3) applyStimulus(0, 32'h0, 8'h80, 1, 9'd0);
    end

    // Mid-period top change, then a top presented on a wrap strobe.
    wrapsSeen = 0;
    for (int i = 0; i < 520; i++) begin
      bit willWrap;
      willWrap = ((mPhase + 64'h0100_0000) >> 32) != 0;
      if (i == 50) applyStimulus(1, 32'h0100_0000, 8'h40, 1, 9'd25);
      else if (i > 50 && willWrap && wrapsSeen == 1)
        applyStimulus(1, 32'h0100_0000, 8'h20, 1, 9'd25);
      else applyStimulus(1, 32'h0100_0000, 8'h00, 0, 9'd25);
      if (i > 50 && willWrap) wrapsSeen++;
      applyStimulus(0, 32'h0, 8'h00, 0, 9'd0);
    end

    // Rest and restart.
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h0100_0000, 8'h00, 0, 9'd40);
    for (int i = 0; i < 3; i++) applyStimulus(1, 32'h0, 8'h00, 0, 9'd40);
    for (int i = 0; i < 5; i++) applyStimulus(1, 32'h0200_0000, 8'h00, 0, 9'd40);

    // Back-to-back strobes.
    for (int i = 0; i < 600; i++) applyStimulus(1, 32'h4000_0000, 8'h00, 0, 9'd77);

    // Asynchronous reset with a sample in flight.
    applyStimulus(1, 32'h0100_0000, 8'h80, 1, 9'd100);
    @(posedge clk);
    #1 stb = 0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_sample", sample, 0);
    checkOutput("midreset_valid", sampleValid, 0);
    checkOutput("midreset_period", periodStb, 0);
    checkOutput("midreset_phase", phase, 0);
    stage1Q.delete();
    sampleQ.delete();
    mPhase = 0;
    mTopActive = 8'h80;
    mTopPending = 8'h80;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) applyStimulus(0, 32'h0, 8'h80, 0, 9'd0);

    // Full-scale envelope with near-100% duty, then zero envelope.
    for (int i = 0; i < 520; i++) applyStimulus(1, 32'h0100_0000, 8'hFF, 1, 9'd511);
    for (int i = 0; i < 20; i++) applyStimulus(1, 32'h0100_0000, 8'hFF, 1, 9'd0);

    // Randomized deltas (including boundary values), tops, envelopes, gaps.
    rd = 32'h0100_0000;
    for (int i = 0; i < 400; i++) begin
      if (i % 20 == 0) begin
        case ($urandom_range(0, 4))
          0: rd = 32'h0;
          1: rd = 32'h8000_0000;
          2: rd = 32'hFFFF_FFFF;
          3: rd = $urandom;
          default: rd = 32'h0100_0000;
        endcase
      end
      applyStimulus(1, rd, 8'($urandom), $urandom_range(0, 7) == 0, 9'($urandom));
      repeat ($urandom_range(0, 2))
        applyStimulus(0, 32'h0, 8'($urandom), $urandom_range(0, 3) == 0, 9'd0);
    end

    repeat (4) applyStimulus(0, 32'h0, 8'h00, 0, 9'd0);
    checkOutput("queue_drain", stage1Q.size() + sampleQ.size(), 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
